// File: rtl/tlcd_bus_receiver.sv
// tlcd_bus_receiver: passive HD44780-style bus snooper keeping DDRAM/CGRAM shadows.
// Define TLCD_RX_FRAME_EN to build the frame-done pulse and frame counter.
module tlcd_bus_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_CYCLES = 50
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        TLCD_E,
  input  logic        TLCD_RS,
  input  logic        TLCD_RW,
  input  logic [7:0]  TLCD_DATA,
  input  logic [4:0]  RD_ADDR,
  output logic [7:0]  RD_CHAR,
  input  logic [5:0]  CG_RD_ADDR,
  output logic [4:0]  CG_RD_DATA,
  output logic        WR_STROBE,
  output logic        WR_IS_DATA,
  output logic [7:0]  WR_BYTE,
  output logic [6:0]  CURSOR_ADDR,
  output logic        DISPLAY_ON,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic        FRAME_DONE,
  output logic [15:0] FRAME_COUNT
);
  localparam int CW = $clog2(BUSY_CYCLES + 33);
  typedef enum logic [1:0] {IDLE, EXEC, CLEAR, HOLD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic [10:0] prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] ac_q, ac_d, ac_inc, ac_dec;
  logic [5:0] cga_q, cga_d;
  logic id_q, id_d, cg_mode_q, cg_mode_d, disp_q, disp_d, ovr_q;
  logic wr_stb_q, wr_rs_q;
  logic [7:0] wr_byte_q, rd_char_q, dd_wd;
  logic [4:0] cg_rd_q, dd_wa, dd_idx;
  logic [7:0] dd_q [32];
  logic [4:0] cg_q [64];
  logic fall, edge_ok, accept, dd_we, cg_we, dd_hit;
  assign fall    = prev_q[10] & ~sync_q[SYNC_STAGES-1][10];
  assign edge_ok = fall & ~prev_q[8];
  assign accept  = edge_ok & (state_q == IDLE);
  assign dd_hit  = (ac_q[6:4] == 3'b000) || (ac_q[6:4] == 3'b100);
  assign dd_idx  = {ac_q[6], ac_q[3:0]};
  // The two visible lines are 0x00-0x27 and 0x40-0x67; stepping wraps between them.
  assign ac_inc  = (ac_q == 7'h27) ? 7'h40 : (ac_q == 7'h67) ? 7'h00 : ac_q + 7'd1;
  assign ac_dec  = (ac_q == 7'h40) ? 7'h27 : (ac_q == 7'h00) ? 7'h67 : ac_q - 7'd1;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ac_d      = ac_q;
    cga_d     = cga_q;
    id_d      = id_q;
    cg_mode_d = cg_mode_q;
    disp_d    = disp_q;
    dd_we     = 1'b0;
    dd_wa     = dd_idx;
    dd_wd     = wr_byte_q;
    cg_we     = 1'b0;
    case (state_q)
      IDLE: state_d = accept ? EXEC : IDLE;
      EXEC: begin
        state_d = HOLD;
        cnt_d   = '0;
        if (wr_rs_q) begin
          if (cg_mode_q) begin
            cg_we = 1'b1;
            cga_d = id_q ? cga_q + 6'd1 : cga_q - 6'd1;
          end else begin
            dd_we = dd_hit;
            ac_d  = id_q ? ac_inc : ac_dec;
          end
        end else if (wr_byte_q[7]) begin
          ac_d      = wr_byte_q[6:0];
          cg_mode_d = 1'b0;
        end else if (wr_byte_q[6]) begin
          cga_d     = wr_byte_q[5:0];
          cg_mode_d = 1'b1;
        end else if (wr_byte_q[5:4] == 2'b00) begin
          if (wr_byte_q[3]) disp_d = wr_byte_q[2];
          else if (wr_byte_q[2]) id_d = wr_byte_q[1];
          else if (wr_byte_q[1]) begin
            ac_d      = '0;
            cg_mode_d = 1'b0;
          end else if (wr_byte_q[0]) begin
            ac_d      = '0;
            id_d      = 1'b1;
            cg_mode_d = 1'b0;
            state_d   = CLEAR;
          end
        end
      end
      CLEAR: begin
        dd_we   = 1'b1;
        dd_wa   = cnt_q[4:0];
        dd_wd   = 8'h20;
        cnt_d   = (cnt_q[4:0] == 5'd31) ? '0 : cnt_q + CW'(1);
        state_d = (cnt_q[4:0] == 5'd31) ? HOLD : CLEAR;
      end
      default: begin
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(BUSY_CYCLES - 1)) ? IDLE : HOLD;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q    <= '0;
      prev_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      ac_q      <= '0;
      cga_q     <= '0;
      id_q      <= 1'b1;
      cg_mode_q <= 1'b0;
      disp_q    <= 1'b0;
      ovr_q     <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_rs_q   <= 1'b0;
      wr_byte_q <= '0;
      rd_char_q <= 8'h20;
      cg_rd_q   <= '0;
      for (int i = 0; i < 32; i++) dd_q[i] <= 8'h20;
      for (int i = 0; i < 64; i++) cg_q[i] <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], {TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA}};
      prev_q    <= sync_q[SYNC_STAGES-1];
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ac_q      <= ac_d;
      cga_q     <= cga_d;
      id_q      <= id_d;
      cg_mode_q <= cg_mode_d;
      disp_q    <= disp_d;
      ovr_q     <= ovr_q | (edge_ok & (state_q != IDLE));
      wr_stb_q  <= accept;
      wr_rs_q   <= accept ? prev_q[9] : wr_rs_q;
      wr_byte_q <= accept ? prev_q[7:0] : wr_byte_q;
      rd_char_q <= dd_q[RD_ADDR];
      cg_rd_q   <= cg_q[CG_RD_ADDR];
      if (dd_we) dd_q[dd_wa] <= dd_wd;
      if (cg_we) cg_q[cga_q] <= wr_byte_q[4:0];
    end
  end
  assign RD_CHAR     = rd_char_q;
  assign CG_RD_DATA  = cg_rd_q;
  assign WR_STROBE   = wr_stb_q;
  assign WR_IS_DATA  = wr_rs_q;
  assign WR_BYTE     = wr_byte_q;
  assign CURSOR_ADDR = ac_q;
  assign DISPLAY_ON  = disp_q;
  assign BUSY        = state_q != IDLE;
  assign OVERRUN     = ovr_q;
`ifdef TLCD_RX_FRAME_EN
  logic frame_done_q, hit31;
  logic [15:0] frame_cnt_q;
  assign hit31 = (state_q == EXEC) & dd_we & (dd_wa == 5'd31);
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= hit31;
      frame_cnt_q  <= hit31 ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end
  end
  assign FRAME_DONE  = frame_done_q;
  assign FRAME_COUNT = frame_cnt_q;
`else
  assign FRAME_DONE  = 1'b0;
  assign FRAME_COUNT = '0;
`endif
endmodule

// File: tb/tb_tlcd_bus_receiver.sv
// tb_tlcd_bus_receiver: directed vector table plus hand sequences for clear, CGRAM, RW, overrun, reset abort.
module tb_tlcd_bus_receiver;
  logic CLK, RST, E, RS, RW;
  logic [7:0] DATA, RD_CHAR, WR_BYTE;
  logic [4:0] RD_ADDR, CG_RD_DATA;
  logic [5:0] CG_RD_ADDR;
  logic WR_STROBE, WR_IS_DATA, DISPLAY_ON, BUSY, OVERRUN, FRAME_DONE;
  logic [6:0] CURSOR_ADDR;
  logic [15:0] FRAME_COUNT;
  int checks = 0, failures = 0, strobes = 0, frames = 0;
  logic last_rs;
  logic [7:0] last_b;
`ifdef TLCD_RX_FRAME_EN
  localparam int EXP_FR = 2;
`else
  localparam int EXP_FR = 0;
`endif
  typedef struct {
    logic rs; logic [7:0] b; logic [4:0] addr; logic [7:0] ch; logic [6:0] ac; logic disp;
  } vec_t;
  vec_t tv [20];
  tlcd_bus_receiver dut (
    .CLK(CLK), .RST(RST), .TLCD_E(E), .TLCD_RS(RS), .TLCD_RW(RW), .TLCD_DATA(DATA),
    .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR), .CG_RD_ADDR(CG_RD_ADDR), .CG_RD_DATA(CG_RD_DATA),
    .WR_STROBE(WR_STROBE), .WR_IS_DATA(WR_IS_DATA), .WR_BYTE(WR_BYTE),
    .CURSOR_ADDR(CURSOR_ADDR), .DISPLAY_ON(DISPLAY_ON), .BUSY(BUSY), .OVERRUN(OVERRUN),
    .FRAME_DONE(FRAME_DONE), .FRAME_COUNT(FRAME_COUNT)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(negedge CLK) begin
    if (WR_STROBE) begin
      strobes++;
      last_rs = WR_IS_DATA;
      last_b  = WR_BYTE;
    end
    if (FRAME_DONE) frames++;
  end
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic rs, input logic [7:0] b, input logic rw);
    @(negedge CLK);
    RS = rs; RW = rw; DATA = b; E = 1'b1;
    repeat (2) @(negedge CLK);
    E = 1'b0;
  endtask
  task automatic pulse(input logic [7:0] b);
    @(negedge CLK);
    RS = 1'b0; RW = 1'b0; DATA = b; E = 1'b1;
    @(negedge CLK);
    E = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    repeat (4) @(negedge CLK);
    while (BUSY && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("idle_timeout", 32'(BUSY), 32'(0));
  endtask
  task automatic wr(input logic rs, input logic [7:0] b);
    xfer(rs, b, 1'b0);
    wait_idle();
  endtask
  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    @(negedge CLK);
    RD_ADDR = a;
    @(negedge CLK);
    v = RD_CHAR;
  endtask
  task automatic cgrd(input logic [5:0] a, output logic [4:0] v);
    @(negedge CLK);
    CG_RD_ADDR = a;
    @(negedge CLK);
    v = CG_RD_DATA;
  endtask
  initial begin
    logic [7:0] v;
    logic [4:0] cv;
    logic [3:0] sp;
    int s0, hi;
    int ra [4];
    ra = '{0, 15, 16, 31};
    tv[0]  = '{1'b0, 8'h80, 5'd0,  8'h20, 7'h00, 1'b0};
    tv[1]  = '{1'b1, 8'h48, 5'd0,  8'h48, 7'h01, 1'b0};
    tv[2]  = '{1'b1, 8'h49, 5'd1,  8'h49, 7'h02, 1'b0};
    tv[3]  = '{1'b0, 8'hA7, 5'd1,  8'h49, 7'h27, 1'b0};
    tv[4]  = '{1'b1, 8'h41, 5'd16, 8'h20, 7'h40, 1'b0};
    tv[5]  = '{1'b1, 8'h42, 5'd16, 8'h42, 7'h41, 1'b0};
    tv[6]  = '{1'b0, 8'hCF, 5'd31, 8'h20, 7'h4F, 1'b0};
    tv[7]  = '{1'b1, 8'h5A, 5'd31, 8'h5A, 7'h50, 1'b0};
    tv[8]  = '{1'b0, 8'hE7, 5'd31, 8'h5A, 7'h67, 1'b0};
    tv[9]  = '{1'b1, 8'h30, 5'd0,  8'h48, 7'h00, 1'b0};
    tv[10] = '{1'b0, 8'h04, 5'd0,  8'h48, 7'h00, 1'b0};
    tv[11] = '{1'b0, 8'h80, 5'd0,  8'h48, 7'h00, 1'b0};
    tv[12] = '{1'b1, 8'h58, 5'd0,  8'h58, 7'h67, 1'b0};
    tv[13] = '{1'b0, 8'hC0, 5'd16, 8'h42, 7'h40, 1'b0};
    tv[14] = '{1'b1, 8'h59, 5'd16, 8'h59, 7'h27, 1'b0};
    tv[15] = '{1'b0, 8'h06, 5'd16, 8'h59, 7'h27, 1'b0};
    tv[16] = '{1'b0, 8'h0C, 5'd1,  8'h49, 7'h27, 1'b1};
    tv[17] = '{1'b0, 8'h30, 5'd1,  8'h49, 7'h27, 1'b1};
    tv[18] = '{1'b0, 8'h02, 5'd0,  8'h58, 7'h00, 1'b1};
    tv[19] = '{1'b0, 8'h08, 5'd0,  8'h58, 7'h00, 1'b0};
    E = 1'b0; RS = 1'b0; RW = 1'b0; DATA = '0; RD_ADDR = '0; CG_RD_ADDR = '0; RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_rd_char", 32'(RD_CHAR), 32'h20);
    check("rst_wr", 32'({WR_STROBE, WR_IS_DATA, WR_BYTE}), 32'(0));
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(5'(ra[i]), v);
      check($sformatf("rst_idx%0d", ra[i]), 32'(v), 32'h20);
    end
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_disp", 32'(DISPLAY_ON), 32'(0));
    check("rst_ac", 32'(CURSOR_ADDR), 32'(0));
    check("rst_ovr", 32'(OVERRUN), 32'(0));
    check("rst_frame", 32'({FRAME_DONE, FRAME_COUNT}), 32'(0));
    for (int i = 0; i < 20; i++) begin
      s0 = strobes;
      wr(tv[i].rs, tv[i].b);
      rd(tv[i].addr, v);
      check($sformatf("v%0d_char", i), 32'(v), 32'(tv[i].ch));
      check($sformatf("v%0d_ac", i), 32'(CURSOR_ADDR), 32'(tv[i].ac));
      check($sformatf("v%0d_disp", i), 32'(DISPLAY_ON), 32'(tv[i].disp));
      check($sformatf("v%0d_strobes", i), 32'(strobes - s0), 32'(1));
      check($sformatf("v%0d_wr", i), 32'({last_rs, last_b}), 32'({tv[i].rs, tv[i].b}));
    end
    wr(1'b0, 8'h80);
    for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h41 + i));
    wr(1'b0, 8'hC0);
    for (int i = 0; i < 16; i++) wr(1'b1, 8'(8'h61 + i));
    rd(5'd0, v);  check("fill_idx0", 32'(v), 32'h41);
    rd(5'd15, v); check("fill_idx15", 32'(v), 32'h50);
    rd(5'd16, v); check("fill_idx16", 32'(v), 32'h61);
    rd(5'd31, v); check("fill_idx31", 32'(v), 32'h70);
    check("frame_pulses", 32'(frames), 32'(EXP_FR));
    check("frame_count", 32'(FRAME_COUNT), 32'(EXP_FR));
    wr(1'b0, 8'h04);
    xfer(1'b0, 8'h01, 1'b0);
    sp = '0;
    hi = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge CLK);
      if (k <= 4) sp[k-1] = WR_STROBE;
      if (BUSY) hi++;
      else if (hi > 0) break;
    end
    check("clr_strobe_timing", 32'(sp), 32'b0100);
    check("clr_busy_len", 32'(hi), 32'(83));
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v);
      check($sformatf("clr_idx%0d", i), 32'(v), 32'h20);
    end
    check("clr_ac", 32'(CURSOR_ADDR), 32'(0));
    wr(1'b1, 8'h61);
    rd(5'd0, v);
    check("clr_id_idx0", 32'(v), 32'h61);
    check("clr_id_ac", 32'(CURSOR_ADDR), 32'(1));
    wr(1'b0, 8'h40);
    for (int i = 0; i < 8; i++) wr(1'b1, 8'(8'h1F - i));
    wr(1'b1, 8'hE5);
    for (int i = 0; i < 10; i++) begin
      cgrd(6'(i), cv);
      check($sformatf("cg_row%0d", i), 32'(cv), (i < 8) ? 32'(31 - i) : (i == 8) ? 32'h05 : 32'(0));
    end
    check("cg_ac_kept", 32'(CURSOR_ADDR), 32'(1));
    s0 = strobes;
    xfer(1'b0, 8'h0C, 1'b1);
    repeat (6) @(negedge CLK);
    check("rw_busy", 32'(BUSY), 32'(0));
    check("rw_strobes", 32'(strobes - s0), 32'(0));
    check("rw_disp", 32'(DISPLAY_ON), 32'(0));
    check("rw_ovr", 32'(OVERRUN), 32'(0));
    s0 = strobes;
    pulse(8'h30);
    repeat (3) @(negedge CLK);
    pulse(8'h0C);
    wait_idle();
    check("ovr_strobes", 32'(strobes - s0), 32'(1));
    check("ovr_set", 32'(OVERRUN), 32'(1));
    check("ovr_dropped_disp", 32'(DISPLAY_ON), 32'(0));
    repeat (20) @(negedge CLK);
    check("ovr_sticky", 32'(OVERRUN), 32'(1));
    xfer(1'b0, 8'h0C, 1'b0);
    repeat (10) @(negedge CLK);
    check("hold_busy", 32'(BUSY), 32'(1));
    check("hold_disp", 32'(DISPLAY_ON), 32'(1));
    RST = 1'b1;
    @(negedge CLK);
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_ovr", 32'(OVERRUN), 32'(0));
    check("abort_disp", 32'(DISPLAY_ON), 32'(0));
    check("abort_ac", 32'(CURSOR_ADDR), 32'(0));
    check("abort_frame", 32'(FRAME_COUNT), 32'(0));
    RST = 1'b0;
    rd(5'd0, v);
    check("abort_idx0", 32'(v), 32'h20);
    cgrd(6'd0, cv);
    check("abort_cg0", 32'(cv), 32'(0));
    repeat (60) @(negedge CLK);
    check("abort_idle", 32'(BUSY), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
